seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for an 8-digit seven-segment display. It steps a 3-bit digit index through the enabled digits. That index feeds the 3-8 digit-select decoder, and a one-hot copy is provided alongside. For each digit, the block presents that digit's 4-bit code to the segment encoder for a programmable dwell time, followed by an optional blanking gap that suppresses ghosting.

---
 rtl/seg_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: walks a 3-bit digit index through the enabled
// digits, showing each code for DIV cycles with an optional BLANK-cycle dark gap.
module seg_scan_ctrl #(
  parameter int unsigned DIV   = 1000,
  parameter int unsigned BLANK = 2,
  parameter int unsigned CW    = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [7:0]  DIG_EN,
  input  logic [31:0] DATA,
  output logic [2:0]  SEL,
  output logic [7:0]  SEL_OH,
  output logic [3:0]  SEG_DATA,
  output logic        SEG_VALID,
  output logic        FRAME
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_e;

  localparam bit          HAS_GAP    = (BLANK != 0);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? (BLANK - 1) : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [7:0]    sel_oh_q, sel_oh_d;
  logic [3:0]    seg_data_q, seg_data_d;
  logic          seg_valid_q, seg_valid_d;
  logic          frame_q, frame_d;

  logic          load_c;
  logic          wrap_c;
  logic          hi_found_c;
  logic [2:0]    hi_idx_c;
  logic [2:0]    lo_idx_c;

  // Lowest enabled index above the current one, and lowest enabled overall.
  always_comb begin
    hi_found_c = 1'b0;
    hi_idx_c   = 3'd0;
    lo_idx_c   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (DIG_EN[i]) begin
        lo_idx_c = 3'(i);
        if (3'(i) > sel_q) begin
          hi_found_c = 1'b1;
          hi_idx_c   = 3'(i);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= 3'd0;
      sel_oh_q    <= 8'h00;
      seg_data_q  <= 4'h0;
      seg_valid_q <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      sel_oh_q    <= sel_oh_d;
      seg_data_q  <= seg_data_d;
      seg_valid_q <= seg_valid_d;
      frame_q     <= frame_d;
    end
  end

  // Next-state: dwell/gap counting and digit selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    load_c  = 1'b0;
    wrap_c  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (EN && (DIG_EN != 8'h00)) begin
          state_d = SHOW;
          sel_d   = lo_idx_c;
          load_c  = 1'b1;
          wrap_c  = 1'b1;
        end
      end
      SHOW, GAP: begin
        if (!EN) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if ((state_q == SHOW) && (cnt_q == DIV_LAST) && HAS_GAP) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (((state_q == SHOW) && (cnt_q == DIV_LAST)) ||
                     ((state_q == GAP) && (cnt_q == BLANK_LAST))) begin
          cnt_d = '0;
          if (DIG_EN != 8'h00) begin
            state_d = SHOW;
            sel_d   = hi_found_c ? hi_idx_c : lo_idx_c;
            load_c  = 1'b1;
            wrap_c  = !hi_found_c;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode; the digit code is captured only when a digit is loaded.
  always_comb begin
    sel_oh_d    = 8'h00;
    seg_valid_d = 1'b0;
    frame_d     = 1'b0;
    seg_data_d  = seg_data_q;
    if (state_d == SHOW) begin
      sel_oh_d    = 8'h01 << sel_d;
      seg_valid_d = 1'b1;
    end
    if (load_c) begin
      seg_data_d = DATA[{sel_d, 2'b00} +: 4];
      frame_d    = wrap_c;
    end
  end

  assign SEL       = sel_q;
  assign SEL_OH    = sel_oh_q;
  assign SEG_DATA  = seg_data_q;
  assign SEG_VALID = seg_valid_q;
  assign FRAME     = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed scoreboard bench for seg_scan_ctrl: one instance with a 1-cycle gap,
// one with no gap, sharing all inputs.
module tb_seg_scan_ctrl;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] oh;
    logic [3:0] data;
    logic       valid;
    logic       frame;
    logic       care_sel;
    logic       care_data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic [7:0]  DIG_EN;
  logic [31:0] DATA;

  logic [2:0] sel_a, sel_b;
  logic [7:0] oh_a, oh_b;
  logic [3:0] data_a, data_b;
  logic       v_a, v_b, f_a, f_b;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  seg_scan_ctrl #(.DIV(4), .BLANK(1), .CW(4)) dut_a (
    .CLK(CLK), .RST(RST), .EN(EN), .DIG_EN(DIG_EN), .DATA(DATA),
    .SEL(sel_a), .SEL_OH(oh_a), .SEG_DATA(data_a), .SEG_VALID(v_a), .FRAME(f_a)
  );

  seg_scan_ctrl #(.DIV(4), .BLANK(0), .CW(4)) dut_b (
    .CLK(CLK), .RST(RST), .EN(EN), .DIG_EN(DIG_EN), .DATA(DATA),
    .SEL(sel_b), .SEL_OH(oh_b), .SEG_DATA(data_b), .SEG_VALID(v_b), .FRAME(f_b)
  );

  task automatic push_show(input logic [2:0] s, input logic [3:0] d, input logic fr);
    exp_t e;
    e = '{sel: s, oh: 8'h01 << s, data: d, valid: 1'b1, frame: fr,
          care_sel: 1'b1, care_data: 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic push_dark(input logic [2:0] s, input logic care_s);
    exp_t e;
    e = '{sel: s, oh: 8'h00, data: 4'h0, valid: 1'b0, frame: 1'b0,
          care_sel: care_s, care_data: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic push_reset();
    exp_t e;
    e = '{sel: 3'd0, oh: 8'h00, data: 4'h0, valid: 1'b0, frame: 1'b0,
          care_sel: 1'b1, care_data: 1'b1};
    exp_q.push_back(e);
  endtask

  // Pop one expectation and compare against the chosen instance right now.
  task automatic chk(input string tag, input int which);
    exp_t       e;
    logic [2:0] o_sel;
    logic [7:0] o_oh;
    logic [3:0] o_data;
    logic       o_v, o_f;
    e = exp_q.pop_front();
    if (which == 0) begin
      o_sel = sel_a; o_oh = oh_a; o_data = data_a; o_v = v_a; o_f = f_a;
    end else begin
      o_sel = sel_b; o_oh = oh_b; o_data = data_b; o_v = v_b; o_f = f_b;
    end
    if (!e.care_sel)  o_sel  = e.sel;
    if (!e.care_data) o_data = e.data;
    checks++;
    assert ({o_sel, o_oh, o_data, o_v, o_f} === {e.sel, e.oh, e.data, e.valid, e.frame})
    else begin
      errors++;
      $error("FAIL %s @%0t: observed sel=%0d oh=%h data=%h valid=%b frame=%b, expected sel=%0d oh=%h data=%h valid=%b frame=%b",
             tag, $time, o_sel, o_oh, o_data, o_v, o_f, e.sel, e.oh, e.data, e.valid, e.frame);
    end
  endtask

  task automatic run(input string tag, input int which);
    while (exp_q.size() != 0) begin
      @(negedge CLK);
      chk(tag, which);
    end
  endtask

  task automatic restart(input logic [7:0] mask);
    @(negedge CLK);
    RST = 1'b1;
    EN  = 1'b0;
    @(negedge CLK);
    RST    = 1'b0;
    DIG_EN = mask;
    EN     = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST    = 1'b1;
    EN     = 1'b0;
    DIG_EN = 8'hFF;
    DATA   = 32'h7654_3210;

    @(negedge CLK);
    push_reset(); chk("reset_a", 0);
    push_reset(); chk("reset_b", 1);
    RST = 1'b0;
    EN  = 1'b1;

    // Full scan, two frames: 4 lit cycles then 1 dark per digit.
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 8; d++) begin
        for (int k = 0; k < 4; k++) push_show(3'(d), 4'(d), (d == 0) && (k == 0));
        push_dark(3'(d), 1'b1);
      end
    push_show(3'd0, 4'd0, 1'b1);
    push_show(3'd0, 4'd0, 1'b0);
    run("full_scan", 0);

    // Asynchronous reset mid-dwell, then restart at lowest enabled digit.
    @(negedge CLK);
    RST    = 1'b1;
    DIG_EN = 8'hF0;
    #1;
    push_reset(); chk("async_reset_a", 0);
    push_reset(); chk("async_reset_b", 1);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 4; k++) push_show(3'd4, 4'd4, k == 0);
    push_dark(3'd4, 1'b1);
    for (int k = 0; k < 4; k++) push_show(3'd5, 4'd5, 1'b0);
    run("reset_restart", 0);

    // Sparse mask without gap: 0,2,7 then wrap.
    restart(8'b1000_0101);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) push_show(3'd0, 4'd0, k == 0);
      for (int k = 0; k < 4; k++) push_show(3'd2, 4'd2, 1'b0);
      for (int k = 0; k < 4; k++) push_show(3'd7, 4'd7, 1'b0);
    end
    push_show(3'd0, 4'd0, 1'b1);
    run("sparse", 1);

    // Single digit: FRAME on every re-entry.
    restart(8'h10);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) push_show(3'd4, 4'd4, k == 0);
      push_dark(3'd4, 1'b1);
    end
    push_show(3'd4, 4'd4, 1'b1);
    run("single", 0);

    // EN dropped mid-dwell.
    restart(8'hFF);
    push_show(3'd0, 4'd0, 1'b1);
    push_show(3'd0, 4'd0, 1'b0);
    run("en_drop_pre", 0);
    EN = 1'b0;
    push_dark(3'd0, 1'b0);
    push_dark(3'd0, 1'b0);
    run("en_drop", 0);

    // Mask cleared mid-dwell: dwell completes, gap, then idle.
    restart(8'hFF);
    push_show(3'd0, 4'd0, 1'b1);
    push_show(3'd0, 4'd0, 1'b0);
    run("mask_clr_pre", 0);
    DIG_EN = 8'h00;
    push_show(3'd0, 4'd0, 1'b0);
    push_show(3'd0, 4'd0, 1'b0);
    push_dark(3'd0, 1'b1);
    push_dark(3'd0, 1'b0);
    push_dark(3'd0, 1'b0);
    run("mask_clr", 0);

    // DATA changed mid-dwell: held until the next digit.
    restart(8'hFF);
    push_show(3'd0, 4'd0, 1'b1);
    push_show(3'd0, 4'd0, 1'b0);
    run("data_chg_pre", 0);
    DATA = 32'hFEDC_BA98;
    push_show(3'd0, 4'd0, 1'b0);
    push_show(3'd0, 4'd0, 1'b0);
    push_dark(3'd0, 1'b1);
    push_show(3'd1, 4'h9, 1'b0);
    run("data_chg", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
